// File: rtl/bubblesort_stream_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : bubblesort_stream_ctrl
//  Description : Streaming wrapper around the parallel-lane array sorter.
//                Collects N words from a valid/ready input stream, loads
//                them lane by lane into the sorter, starts it, waits for
//                its interrupt (with timeout), snapshots the sorted lanes
//                and replays them on a valid/ready output stream.
//  Revision    : 1.0  initial release
// ============================================================================
module bubblesort_stream_ctrl #(
    parameter int WIDTH   = 8,
    parameter int N       = 7,
    parameter int TIMEOUT = 256
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 s_valid_i,
    input  logic [WIDTH-1:0]     s_data_i,
    output logic                 s_ready_o,
    output logic                 m_valid_o,
    output logic [WIDTH-1:0]     m_data_o,
    output logic                 m_last_o,
    input  logic                 m_ready_i,
    input  logic                 abort_i,
    output logic                 busy_o,
    output logic                 err_o,
    output logic [N-1:0]         sort_load_o,
    output logic [N*WIDTH-1:0]   sort_writedata_o,
    output logic                 sort_start_o,
    output logic                 sort_abort_o,
    input  logic [N*WIDTH-1:0]   sort_readdata_i,
    input  logic                 sort_interrupt_i
);

    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [KW-1:0] C_LAST_LANE = KW'(N - 1);
    localparam logic [CW-1:0] C_CNT_LAST  = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_FILL      = 3'd0,
        ST_LOAD_LAST = 3'd1,
        ST_START     = 3'd2,
        ST_WAIT      = 3'd3,
        ST_DRAIN     = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [KW-1:0]        k_q, k_d;
    logic [KW-1:0]        j_q, j_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [WIDTH-1:0]     snap_q [N];
    logic [WIDTH-1:0]     snap_d [N];
    logic [N*WIDTH-1:0]   wdata_q, wdata_d;
    logic [N-1:0]         load_q, load_d;
    logic                 start_q, start_d;
    logic                 sabort_q, sabort_d;
    logic                 err_q, err_d;
    logic                 s_ready_q, s_ready_d;
    logic                 busy_q, busy_d;
    logic                 m_valid_q, m_valid_d;
    logic [WIDTH-1:0]     m_data_q, m_data_d;
    logic                 m_last_q, m_last_d;

    logic                 w_hs_in;
    logic                 w_hs_out;
    logic                 w_idle;
    logic [KW-1:0]        w_j_nxt;

    // Handshakes use the registered ready/valid, so no input reaches an output combinationally.
    assign w_hs_in  = s_valid_i & s_ready_q;
    assign w_hs_out = m_valid_q & m_ready_i;
    assign w_idle   = (state_q == ST_FILL) && (k_q == '0);
    assign w_j_nxt  = j_q + 1'b1;

    // Next-state and next-output decode; every output is registered from these _d values.
    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        j_d       = j_q;
        cnt_d     = cnt_q;
        snap_d    = snap_q;
        wdata_d   = wdata_q;
        load_d    = '0;
        start_d   = 1'b0;
        sabort_d  = 1'b0;
        err_d     = err_q;
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        m_last_d  = m_last_q;

        case (state_q)
            ST_FILL: begin
                if (w_hs_in) begin
                    wdata_d[k_q*WIDTH +: WIDTH] = s_data_i;
                    load_d[k_q]                 = 1'b1;
                    if (k_q == '0) begin
                        err_d = 1'b0;
                    end
                    if (k_q == C_LAST_LANE) begin
                        k_d     = '0;
                        state_d = ST_LOAD_LAST;
                    end else begin
                        k_d = k_q + 1'b1;
                    end
                end
            end
            ST_LOAD_LAST: begin
                state_d = ST_START;
            end
            ST_START: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // Interrupt takes priority over a coincident timeout.
                if (sort_interrupt_i) begin
                    for (int l = 0; l < N; l++) begin
                        snap_d[l] = sort_readdata_i[l*WIDTH +: WIDTH];
                    end
                    j_d       = '0;
                    m_valid_d = 1'b1;
                    m_data_d  = sort_readdata_i[WIDTH-1:0];
                    m_last_d  = (N == 1);
                    state_d   = ST_DRAIN;
                end else if (cnt_q == C_CNT_LAST) begin
                    sabort_d = 1'b1;
                    err_d    = 1'b1;
                    k_d      = '0;
                    state_d  = ST_FILL;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                if (w_hs_out) begin
                    if (j_q == C_LAST_LANE) begin
                        j_d       = '0;
                        k_d       = '0;
                        m_valid_d = 1'b0;
                        m_last_d  = 1'b0;
                        state_d   = ST_FILL;
                    end else begin
                        j_d      = w_j_nxt;
                        m_data_d = snap_q[w_j_nxt];
                        m_last_d = (w_j_nxt == C_LAST_LANE);
                    end
                end
            end
            default: begin
                state_d = ST_FILL;
                k_d     = '0;
            end
        endcase

        // Host abort overrides everything above, except when already idle.
        if (abort_i && !w_idle) begin
            state_d   = ST_FILL;
            k_d       = '0;
            j_d       = '0;
            cnt_d     = cnt_q;
            snap_d    = snap_q;
            wdata_d   = wdata_q;
            load_d    = '0;
            start_d   = 1'b0;
            err_d     = err_q;
            m_valid_d = 1'b0;
            m_last_d  = 1'b0;
            m_data_d  = m_data_q;
            sabort_d  = (state_q == ST_START) || (state_q == ST_WAIT);
        end

        if (state_d == ST_START && state_q == ST_LOAD_LAST) begin
            start_d = 1'b1;
        end
        s_ready_d = (state_d == ST_FILL);
        busy_d    = !((state_d == ST_FILL) && (k_d == '0));
    end

    // State and registered outputs, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_FILL;
            k_q       <= '0;
            j_q       <= '0;
            cnt_q     <= '0;
            for (int l = 0; l < N; l++) begin
                snap_q[l] <= '0;
            end
            wdata_q   <= '0;
            load_q    <= '0;
            start_q   <= 1'b0;
            sabort_q  <= 1'b0;
            err_q     <= 1'b0;
            s_ready_q <= 1'b0;
            busy_q    <= 1'b0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_last_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            j_q       <= j_d;
            cnt_q     <= cnt_d;
            snap_q    <= snap_d;
            wdata_q   <= wdata_d;
            load_q    <= load_d;
            start_q   <= start_d;
            sabort_q  <= sabort_d;
            err_q     <= err_d;
            s_ready_q <= s_ready_d;
            busy_q    <= busy_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_last_q  <= m_last_d;
        end
    end

    assign s_ready_o        = s_ready_q;
    assign m_valid_o        = m_valid_q;
    assign m_data_o         = m_data_q;
    assign m_last_o         = m_last_q;
    assign busy_o           = busy_q;
    assign err_o            = err_q;
    assign sort_load_o      = load_q;
    assign sort_writedata_o = wdata_q;
    assign sort_start_o     = start_q;
    assign sort_abort_o     = sabort_q;

endmodule
`default_nettype wire

// File: tb/tb_bubblesort_stream_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bubblesort_stream_ctrl
//  Description : Self-checking bench for bubblesort_stream_ctrl with a
//                behavioural ascending sorter and an output scoreboard.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_bubblesort_stream_ctrl;

    localparam int W  = 8;
    localparam int NL = 7;
    localparam int TO = 20;

    logic              clk;
    logic              rst;
    logic              s_valid_i;
    logic [W-1:0]      s_data_i;
    logic              s_ready_o;
    logic              m_valid_o;
    logic [W-1:0]      m_data_o;
    logic              m_last_o;
    logic              m_ready_i;
    logic              abort_i;
    logic              busy_o;
    logic              err_o;
    logic [NL-1:0]     sort_load_o;
    logic [NL*W-1:0]   sort_writedata_o;
    logic              sort_start_o;
    logic              sort_abort_o;
    logic [NL*W-1:0]   sort_readdata_i;
    logic              sort_interrupt_i;

    int                n_vec;
    int                n_err;
    int                n_pop;
    bit                sorter_en;
    int                sort_dly;
    logic [W:0]        exp_q [$];

    bubblesort_stream_ctrl #(.WIDTH(W), .N(NL), .TIMEOUT(TO)) u_dut (
        .clk              (clk),
        .rst              (rst),
        .s_valid_i        (s_valid_i),
        .s_data_i         (s_data_i),
        .s_ready_o        (s_ready_o),
        .m_valid_o        (m_valid_o),
        .m_data_o         (m_data_o),
        .m_last_o         (m_last_o),
        .m_ready_i        (m_ready_i),
        .abort_i          (abort_i),
        .busy_o           (busy_o),
        .err_o            (err_o),
        .sort_load_o      (sort_load_o),
        .sort_writedata_o (sort_writedata_o),
        .sort_start_o     (sort_start_o),
        .sort_abort_o     (sort_abort_o),
        .sort_readdata_i  (sort_readdata_i),
        .sort_interrupt_i (sort_interrupt_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [NL*W-1:0] sort_lanes(input logic [NL*W-1:0] in);
        logic [W-1:0] a [NL];
        logic [W-1:0] t;
        logic [NL*W-1:0] out;
        for (int i = 0; i < NL; i++) a[i] = in[i*W +: W];
        for (int p = 0; p < NL; p++) begin
            for (int i = 0; i < NL - 1; i++) begin
                if (a[i] > a[i+1]) begin
                    t = a[i]; a[i] = a[i+1]; a[i+1] = t;
                end
            end
        end
        for (int i = 0; i < NL; i++) out[i*W +: W] = a[i];
        return out;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Behavioural sorter: answers a start pulse after sort_dly cycles, then scrambles its read lanes.
    initial begin
        logic [NL*W-1:0] srt;
        sort_interrupt_i = 1'b0;
        sort_readdata_i  = '0;
        forever begin
            @(negedge clk);
            if (sort_start_o && sorter_en) begin
                srt = sort_lanes(sort_writedata_o);
                repeat (sort_dly) @(posedge clk);
                #1;
                sort_readdata_i  = srt;
                sort_interrupt_i = 1'b1;
                @(posedge clk);
                #1;
                sort_interrupt_i = 1'b0;
                sort_readdata_i  = ~srt;
            end
        end
    end

    // Output scoreboard: every valid cycle must show the head entry; pop on handshake.
    always @(negedge clk) begin
        if (m_valid_o) begin
            if (exp_q.size() == 0) begin
                check_value("spurious_m_valid", 64'(m_valid_o), 64'd0);
            end else begin
                check_value("m_data", 64'(m_data_o), 64'(exp_q[0][W-1:0]));
                check_value("m_last", 64'(m_last_o), 64'(exp_q[0][W]));
                if (m_ready_i) begin
                    void'(exp_q.pop_front());
                    n_pop++;
                end
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check_value({tag, "_s_ready"}, 64'(s_ready_o), 64'd0);
        check_value({tag, "_m_valid"}, 64'(m_valid_o), 64'd0);
        check_value({tag, "_m_data"},  64'(m_data_o),  64'd0);
        check_value({tag, "_m_last"},  64'(m_last_o),  64'd0);
        check_value({tag, "_busy"},    64'(busy_o),    64'd0);
        check_value({tag, "_err"},     64'(err_o),     64'd0);
        check_value({tag, "_load"},    64'(sort_load_o), 64'd0);
        check_value({tag, "_wdata"},   64'(sort_writedata_o), 64'd0);
        check_value({tag, "_start"},   64'(sort_start_o), 64'd0);
        check_value({tag, "_sabort"},  64'(sort_abort_o), 64'd0);
    endtask

    task automatic send_word(input int k, input logic [W-1:0] d);
        logic [NL-1:0] exp_load;
        int t;
        s_valid_i = 1'b1;
        s_data_i  = d;
        t = 0;
        while (!s_ready_o && t < 50) begin
            tick();
            t++;
        end
        if (!s_ready_o) check_value("s_ready_timeout", 64'(s_ready_o), 64'd1);
        tick();
        exp_load    = '0;
        exp_load[k] = 1'b1;
        check_value("load_strobe", 64'(sort_load_o), 64'(exp_load));
        check_value("load_lane",   64'(sort_writedata_o[k*W +: W]), 64'(d));
        if (k == 0) check_value("err_clear_first_word", 64'(err_o), 64'd0);
    endtask

    task automatic run_job(input logic [NL*W-1:0] words, input bit push);
        logic [NL*W-1:0] srt;
        if (push) begin
            srt = sort_lanes(words);
            for (int l = 0; l < NL; l++) exp_q.push_back({(l == NL - 1), srt[l*W +: W]});
        end
        for (int k = 0; k < NL; k++) send_word(k, words[k*W +: W]);
        s_valid_i = 1'b0;
        tick();
        check_value("start_pulse", 64'(sort_start_o), 64'd1);
        check_value("load_idle_at_start", 64'(sort_load_o), 64'd0);
    endtask

    task automatic wait_drain(input bit toggle);
        logic [3:0] pat;
        int t;
        pat = 4'b1001;
        t = 0;
        while (exp_q.size() > 0 && t < 300) begin
            m_ready_i = toggle ? pat[t % 4] : 1'b1;
            tick();
            t++;
        end
        m_ready_i = 1'b1;
        check_value("drain_left", 64'(exp_q.size()), 64'd0);
        check_value("ready_after_drain", 64'(s_ready_o), 64'd1);
        check_value("valid_after_drain", 64'(m_valid_o), 64'd0);
        check_value("busy_after_drain",  64'(busy_o), 64'd0);
    endtask

    initial begin
        logic [NL*W-1:0] v1, v2, v3;
        int t;
        int base;
        n_vec = 0; n_err = 0; n_pop = 0;
        sorter_en = 1'b1;
        sort_dly  = 5;
        rst = 1'b0; s_valid_i = 1'b0; s_data_i = '0;
        m_ready_i = 1'b1; abort_i = 1'b0;
        v1 = {8'd50, 8'd70, 8'd30, 8'd20, 8'd10, 8'd40, 8'd80};
        v2 = {8'd3, 8'd255, 8'd0, 8'd128, 8'd7, 8'd7, 8'd64};
        v3 = {8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd9};

        tick(); tick();
        check_reset_outputs("reset");
        rst = 1'b1;
        tick();
        check_value("ready_after_reset", 64'(s_ready_o), 64'd1);
        check_value("busy_idle", 64'(busy_o), 64'd0);

        // Basic job, continuous streams.
        run_job(v1, 1'b1);
        wait_drain(1'b0);
        check_value("err_basic", 64'(err_o), 64'd0);

        // Same job with output back-pressure.
        run_job(v1, 1'b1);
        wait_drain(1'b1);

        // Abort after three words; the coincident fourth word must be dropped.
        for (int k = 0; k < 3; k++) send_word(k, 8'(k + 11));
        s_valid_i = 1'b1; s_data_i = 8'h99; abort_i = 1'b1;
        tick();
        abort_i = 1'b0; s_valid_i = 1'b0;
        check_value("abort_fill_load", 64'(sort_load_o), 64'd0);
        check_value("abort_fill_busy", 64'(busy_o), 64'd0);
        check_value("abort_fill_sabort", 64'(sort_abort_o), 64'd0);
        check_value("abort_fill_start", 64'(sort_start_o), 64'd0);
        check_value("abort_fill_ready", 64'(s_ready_o), 64'd1);
        run_job(v2, 1'b1);
        wait_drain(1'b0);

        // Sorter timeout.
        sorter_en = 1'b0;
        run_job(v3, 1'b0);
        t = 0;
        while (!sort_abort_o && t < 100) begin
            tick();
            t++;
        end
        check_value("timeout_wait_cycles", 64'(t - 1), 64'(TO));
        check_value("timeout_err", 64'(err_o), 64'd1);
        check_value("timeout_busy", 64'(busy_o), 64'd0);
        tick();
        check_value("timeout_abort_one_cycle", 64'(sort_abort_o), 64'd0);
        check_value("timeout_err_sticky", 64'(err_o), 64'd1);
        sorter_en = 1'b1;
        run_job(v1, 1'b1);
        wait_drain(1'b0);

        // Abort while draining lane 2.
        base = n_pop;
        run_job(v2, 1'b1);
        m_ready_i = 1'b1;
        t = 0;
        while ((n_pop - base) < 2 && t < 100) begin
            tick();
            t++;
        end
        check_value("drain_reach_lane2", 64'(n_pop - base), 64'd2);
        m_ready_i = 1'b0; abort_i = 1'b1;
        tick();
        abort_i = 1'b0; m_ready_i = 1'b1;
        check_value("abort_drain_valid", 64'(m_valid_o), 64'd0);
        check_value("abort_drain_sabort", 64'(sort_abort_o), 64'd0);
        check_value("abort_drain_ready", 64'(s_ready_o), 64'd1);
        check_value("abort_drain_busy", 64'(busy_o), 64'd0);
        exp_q.delete();

        // Reset in the middle of WAIT; the late interrupt must be ignored.
        sort_dly = 10;
        run_job(v3, 1'b0);
        tick(); tick(); tick();
        rst = 1'b0;
        tick();
        check_reset_outputs("midwait_reset");
        rst = 1'b1;
        repeat (15) tick();
        check_value("late_irq_valid", 64'(m_valid_o), 64'd0);
        check_value("late_irq_busy", 64'(busy_o), 64'd0);
        sort_dly = 5;
        run_job(v2, 1'b1);
        wait_drain(1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
